// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data SRAM.
// Each request is latched, driven for one ACCESS cycle, then acked in RESP.
module sram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  ack0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ack1,

    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [DATA_WIDTH-1:0] readData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    owner_q, owner_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic                    pick;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        // On a tie the port that was not served last wins; otherwise the sole requester.
        pick         = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d      = pick;
                    last_grant_d = pick;
                    we_d         = pick ? we1    : we0;
                    addr_d       = pick ? addr1  : addr0;
                    wdata_d      = pick ? wdata1 : wdata0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (owner_q) rdata1_d = readData;
                    else         rdata0_d = readData;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign memWrite  = (state_q == ACCESS) &&  we_q;
    assign memRead   = (state_q == ACCESS) && !we_q;
    assign ack0      = (state_q == RESP)   && !owner_q;
    assign ack1      = (state_q == RESP)   &&  owner_q;
    assign address   = addr_q;
    assign writeData = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed table, corner-case sequences
// and randomized traffic checked against a transaction-schedule reference model.
module tb_sram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [31:0] rdata0, rdata1, address, writeData, readData;
    logic        ack0, ack1, memWrite, memRead;

    always #5 clock = ~clock;

    sram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .address(address), .writeData(writeData), .memWrite(memWrite), .memRead(memRead),
        .readData(readData)
    );

    function automatic logic [31:0] preload(input int i);
        case (i)
            0:       return 32'd7;
            1:       return 32'd5;
            5:       return 32'd4;
            default: return 32'(i);
        endcase
    endfunction

    // SRAM behaviour: combinational read, write at the clock edge.
    logic [31:0] sram [32];
    bit          sram_ready = 1'b0;
    always @(posedge clock) begin
        if (!sram_ready) begin
            for (int i = 0; i < 32; i++) sram[i] <= preload(i);
            sram_ready <= 1'b1;
        end else if (memWrite) begin
            sram[address[4:0]] <= writeData;
        end
    end
    assign readData = memRead ? sram[address[4:0]] : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction granted at edge n occupies the bus during
    // the cycle after edge n, acks in the next one, and the next grant is at n+3.
    int          edge_n   = 0;
    int          free_at  = 0;
    int          acc_edge = -10;
    bit          own, twe, last = 1'b1;
    logic [31:0] taddr, twdata;
    logic [31:0] exp_rd [2];
    logic [31:0] ref_mem [32];

    task automatic model_reset();
        free_at   = 0;
        acc_edge  = -10;
        last      = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic step();
        bit in_acc, in_resp, p;
        @(posedge clock);
        edge_n++;
        if (edge_n == acc_edge + 1) begin
            if (twe) ref_mem[taddr[4:0]] = twdata;
            else     exp_rd[own]        = ref_mem[taddr[4:0]];
        end
        if (edge_n >= free_at && (req0 || req1)) begin
            p        = (req0 && req1) ? !last : !req0;
            own      = p;
            twe      = p ? we1    : we0;
            taddr    = p ? addr1  : addr0;
            twdata   = p ? wdata1 : wdata0;
            last     = p;
            acc_edge = edge_n;
            free_at  = edge_n + 3;
        end
        @(negedge clock);
        in_acc  = (edge_n == acc_edge);
        in_resp = (edge_n == acc_edge + 1);
        chk("memRead",  32'(memRead),  32'(in_acc && !twe));
        chk("memWrite", 32'(memWrite), 32'(in_acc &&  twe));
        if (in_acc) begin
            chk("address", address, taddr);
            chk("writeData", writeData, twdata);
        end
        chk("ack0",   32'(ack0), 32'(in_resp && !own));
        chk("ack1",   32'(ack1), 32'(in_resp &&  own));
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
    endtask

    task automatic set_port(input bit p, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic drop_req(input bit p);
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // Called just after a falling edge; the pulse ends well before the next rising edge.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_memWrite"}, 32'(memWrite), 32'd0);
        chk({tag, "_memRead"},  32'(memRead),  32'd0);
        chk({tag, "_ack0"},     32'(ack0),     32'd0);
        chk({tag, "_ack1"},     32'(ack1),     32'd0);
        chk({tag, "_address"},  address,       32'd0);
        chk({tag, "_wdata"},    writeData,     32'd0);
        chk({tag, "_rdata0"},   rdata0,        32'd0);
        chk({tag, "_rdata1"},   rdata1,        32'd0);
        #1;
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        model_reset();
    endtask

    task automatic run_txn(input bit p, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        bit got = 1'b0;
        lat = -1;
        set_port(p, 1'b1, w, a, d);
        for (int k = 0; k < 8; k++) begin
            step();
            if (p ? ack1 : ack0) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        drop_req(p);
        chk("txn_ack_seen", 32'(got), 32'd1);
        step();
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic agent(input bit p);
        logic r, a;
        r = p ? req1 : req0;
        a = p ? ack1 : ack0;
        if (r && a) begin
            if ($urandom_range(3) != 0) drop_req(p);
        end else if (r && acc_edge == edge_n && own == p && $urandom_range(3) == 0) begin
            set_port(p, 1'b0, 1'($urandom), $urandom, $urandom);
        end else if (!r && $urandom_range(2) == 0) begin
            set_port(p, 1'b1, 1'($urandom), $urandom, $urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   lat, t0, t1, nack;
        int   order [$];

        for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0007};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0000_1234, 32'h0000_0000};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,         32'h0000_1234};
        tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFE1, 32'h0,         32'h0000_0005};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_0000, 32'h0000_1234};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000};

        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_memRead",  32'(memRead),  32'd0);
        chk("rst_memWrite", 32'(memWrite), 32'd0);
        chk("rst_ack0",     32'(ack0),     32'd0);
        chk("rst_ack1",     32'(ack1),     32'd0);
        chk("rst_rdata0",   rdata0,        32'd0);
        chk("rst_rdata1",   rdata1,        32'd0);
        chk("rst_address",  address,       32'd0);
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat);
            chk("tbl_latency", 32'(lat), 32'd1);
            chk("tbl_rdata", tbl[i].port ? rdata1 : rdata0, tbl[i].exp_rdata);
        end

        // Simultaneous requests after reset: port 0 first, acks three cycles apart.
        pulse_reset("rst_sim");
        set_port(1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
        t0 = -1; t1 = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ack0 && t0 < 0) begin t0 = k; drop_req(1'b0); end
            if (ack1 && t1 < 0) begin t1 = k; drop_req(1'b1); end
            if (t0 >= 0 && t1 >= 0) break;
        end
        chk("sim_first_ack0", 32'(t0), 32'd1);
        chk("sim_ack_spacing", 32'(t1 - t0), 32'd3);
        chk("sim_rdata0", rdata0, 32'd5);
        chk("sim_rdata1", rdata1, 32'd4);
        step();

        // Both ports held high: grants alternate strictly.
        set_port(1'b0, 1'b1, 1'b0, $urandom, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, $urandom, 32'd0);
        nack = 0;
        for (int k = 0; k < 30 && nack < 6; k++) begin
            step();
            if (ack0) begin order.push_back(0); nack++; end
            if (ack1) begin order.push_back(1); nack++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("alt_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < order.size(); i++) chk("alt_order", 32'(order[i]), 32'(i % 2));
        repeat (2) step();

        // Reset during a write ACCESS: nothing committed, no ack.
        set_port(1'b0, 1'b1, 1'b1, 32'd2, 32'hFFFF_FFFF);
        step();
        chk("rstacc_memWrite_before", 32'(memWrite), 32'd1);
        pulse_reset("rst_acc");
        repeat (3) step();
        run_txn(1'b0, 1'b0, 32'd2, 32'd0, lat);
        chk("rstacc_readback", rdata0, 32'd2);

        // Reset during RESP: ack drops at once.
        set_port(1'b1, 1'b1, 1'b0, 32'd5, 32'd0);
        step();
        step();
        chk("rstresp_ack1_before", 32'(ack1), 32'd1);
        pulse_reset("rst_resp");
        repeat (2) step();

        // Port 1 drops its request right after the grant; inputs change too.
        set_port(1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
        step();
        set_port(1'b1, 1'b0, 1'b1, 32'h1F, 32'hBAD0_BAD0);
        step();
        chk("drop_ack1", 32'(ack1), 32'd1);
        chk("drop_rdata1", rdata1, 32'd5);
        repeat (3) step();
        chk("drop_no_second", 32'(memRead | memWrite), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step();
            agent(1'b0);
            agent(1'b1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 32-word x 32-bit data SRAM.
- Lets two requesters share the single SRAM port: port 0 (CPU load/store unit) and port 1 (loader/debug/DMA).
- Each request is latched, the SRAM control pins are driven for exactly one access cycle, read data is registered, and a one-cycle ack is returned to the owner.

Parameters:
- DATA_WIDTH, 32, width of the data buses.
- ADDR_WIDTH, 32, width of the address buses. Passed through unchanged; the SRAM decodes address[4:0].

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 request. Held high, with we0/addr0/wdata0 stable, until ack0.
- we0  input  1  port 0: 1 = write, 0 = read.
- addr0  input  ADDR_WIDTH  port 0 word address.
- wdata0  input  DATA_WIDTH  port 0 write data.
- rdata0  output  DATA_WIDTH  port 0 registered read data.
- ack0  output  1  port 0 one-cycle completion pulse.
- req1, we1, addr1, wdata1, rdata1, ack1: same definitions as port 0, for port 1.
- address  output  ADDR_WIDTH  to SRAM address.
- writeData  output  DATA_WIDTH  to SRAM writeData.
- memWrite  output  1  to SRAM memWrite.
- memRead  output  1  to SRAM memRead.
- readData  input  DATA_WIDTH  from SRAM readData. Combinational read; high-Z when memRead=0.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - memWrite = memRead = 0.
  - address = writeData = 0.
  - ack0 = ack1 = 0.
  - rdata0 = rdata1 = 0.
  - last_grant = 1, so port 0 wins the first tie.
- IDLE state:
  - req sampled at the rising edge.
  - Only one request: grant it.
  - Both requesting: grant the port != last_grant.
  - On grant:
    - Latch owner, we, addr and wdata into internal registers.
    - last_grant <= owner.
    - Go to ACCESS.
  - No request: stay in IDLE.
- ACCESS state (exactly 1 cycle):
  - address and writeData driven from the latched registers.
  - Latched write: memWrite = 1, memRead = 0. The SRAM commits the write at the edge ending ACCESS.
  - Latched read: memRead = 1, memWrite = 0. readData is captured into the owner's rdata register at the edge ending ACCESS.
  - Always go to RESP.
- RESP state (exactly 1 cycle):
  - memWrite = memRead = 0.
  - Owner's ack is high for this one cycle only.
  - rdata is valid from RESP onward and held until that port's next read completes.
  - Writes leave rdata unchanged.
  - Next state = IDLE.
- Latency and throughput:
  - Request sampled at edge k → ACCESS during cycle k+1 → ack during cycle k+2.
  - Maximum throughput: one transaction per 3 cycles.
- Rules:
  - memWrite and memRead are never high together.
  - Both are low outside ACCESS.
  - ack0 and ack1 are never high together.
- Boundary conditions:
  - req deasserted after grant: the transaction still completes and acks. Latched values are used, so later input changes are ignored.
  - req still high in the IDLE cycle after ack: treated as a new request and arbitrated normally. A requester wanting one access must drop req on the edge where it sees ack.
  - Both ports continuously requesting: grants alternate strictly 0, 1, 0, 1, …
  - The non-granted request waits: no ack and no change to its rdata.
  - Reset asserted during ACCESS: memWrite drops immediately, no write is committed, no ack is issued.
  - Reset asserted during RESP: ack drops immediately.
  - Address bits [31:5] are passed to the SRAM unchanged, with no checking. Aliasing is the SRAM's behaviour.

Test Plan:
- Reset, then port 0 reads addr 0 (preload 7) → memRead=1 only in cycle k+1, ack0 in cycle k+2, rdata0=7, ack1 never high.
- Port 1 writes 0x00001234 to addr 3, then reads addr 3 → memWrite one cycle, ack1; read returns rdata1=0x00001234; rdata0 unchanged.
- req0 and req1 rise on the same edge after reset, reading addr 1 (5) and addr 5 (4) → port 0 served first (rdata0=5), then port 1 (rdata1=4); acks 3 cycles apart.
- Both requests held high for 6 transactions → grant order 0,1,0,1,0,1; no cycle has both acks high or memRead and memWrite together.
- Port 0 write of 0xFFFFFFFF to addr 2; reset pulsed mid-ACCESS before the edge → no ack0; state back in IDLE; a subsequent read of addr 2 returns 2.
- Port 1 read request dropped one cycle after grant → ack1 still pulses with correct data; no second transaction starts.
